// File: rtl/gpi_irq_ctrl.sv
// gpi_irq_ctrl: slot-bus controller for external switch/button inputs.
// Each input bit is synchronised, debounced and edge-detected; enabled
// edges latch into a sticky PENDING register that drives one level irq.
module gpi_irq_ctrl #(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [4:0]    addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic [W-1:0]  data_in,
  output logic          irq
);

  localparam logic [4:0] A_DATA     = 5'd0;
  localparam logic [4:0] A_RISE_EN  = 5'd1;
  localparam logic [4:0] A_FALL_EN  = 5'd2;
  localparam logic [4:0] A_PENDING  = 5'd3;
  localparam logic [4:0] A_DB_LIMIT = 5'd4;
  localparam logic [4:0] A_CTRL     = 5'd5;

  logic [W-1:0]  s1, s2;
  logic [W-1:0]  stable, stable_nxt;
  logic [CW-1:0] cnt     [W];
  logic [CW-1:0] cnt_nxt [W];

  logic [W-1:0]  rise_en, fall_en, pending, pending_nxt;
  logic [CW-1:0] db_limit;
  logic          ctrl_en;

  logic          wr_en;
  logic [W-1:0]  rise, fall, pend_set, pend_clr;

  // Reads carry no side effects; the strobe and unused write bits are
  // intentionally left unconnected.
  logic unused_bits;
  assign unused_bits = &{1'b0, read, wr_data};

  assign wr_en = cs & write;

  // Two-flop synchroniser for the asynchronous pins.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= data_in;
      s2 <= s1;
    end
  end

  // Per-bit debounce: count while s2 disagrees with stable, accept at limit.
  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < W; i++) begin
      cnt_nxt[i] = cnt[i];
      if (s2[i] == stable[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] >= db_limit) begin
        stable_nxt[i] = s2[i];
        cnt_nxt[i]    = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  // Debounced level and per-bit counters.
  // NOTE: the counter array is built from flops, not RAM, so it is reset
  // explicitly; a debounce in progress must be discarded on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < W; i++) cnt[i] <= '0;
    end else begin
      stable <= stable_nxt;
      for (int i = 0; i < W; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  // Edge events and sticky pending update; a set beats a same-edge clear.
  always_comb begin
    rise        = stable_nxt & ~stable;
    fall        = ~stable_nxt & stable;
    pend_set    = (rise & rise_en) | (fall & fall_en);
    pend_clr    = (wr_en && addr == A_PENDING) ? wr_data[W-1:0] : '0;
    pending_nxt = pend_set | (pending & ~pend_clr);
  end

  // Software-visible configuration and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_en  <= '0;
      fall_en  <= '0;
      pending  <= '0;
      db_limit <= '0;
      ctrl_en  <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (wr_en) begin
        case (addr)
          A_RISE_EN:  rise_en  <= wr_data[W-1:0];
          A_FALL_EN:  fall_en  <= wr_data[W-1:0];
          A_DB_LIMIT: db_limit <= wr_data[CW-1:0];
          A_CTRL:     ctrl_en  <= wr_data[0];
          default:    ;
        endcase
      end
    end
  end

  // Read mux, combinational from addr and register state.
  always_comb begin
    rd_data = '0;
    case (addr)
      A_DATA:     rd_data = 32'(stable);
      A_RISE_EN:  rd_data = 32'(rise_en);
      A_FALL_EN:  rd_data = 32'(fall_en);
      A_PENDING:  rd_data = 32'(pending);
      A_DB_LIMIT: rd_data = 32'(db_limit);
      A_CTRL:     rd_data = {31'd0, ctrl_en};
      default:    rd_data = '0;
    endcase
  end

  assign irq = ctrl_en & (|pending);

endmodule

// File: tb/tb_gpi_irq_ctrl.sv
// Self-checking bench for gpi_irq_ctrl: directed scenarios followed by
// randomized bus traffic and pin activity against a behavioural model.
module tb_gpi_irq_ctrl;

  localparam int W  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cs = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [4:0]    addr = '0;
  logic [31:0]   wr_data = '0;
  logic [31:0]   rd_data;
  logic [W-1:0]  data_in = '0;
  logic          irq;

  int checks = 0;
  int failures = 0;

  // Reference model state: pin history and per-bit "disagreeing since" edge.
  logic [W-1:0]  m_s1, m_s2, m_stable, m_rise_en, m_fall_en, m_pend;
  logic [CW-1:0] m_lim;
  logic          m_ctrl;
  int            m_div [W];
  int            n_edge = 0;

  gpi_irq_ctrl #(.W(W), .CW(CW)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .data_in (data_in),
    .irq     (irq)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_reg(input int a);
    case (a)
      0:       return 32'(m_stable);
      1:       return 32'(m_rise_en);
      2:       return 32'(m_fall_en);
      3:       return 32'(m_pend);
      4:       return 32'(m_lim);
      5:       return {31'd0, m_ctrl};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0;
    m_rise_en = '0; m_fall_en = '0; m_pend = '0;
    m_lim = '0; m_ctrl = 1'b0;
    for (int i = 0; i < W; i++) m_div[i] = -1;
  endtask

  // Predict the state after the coming edge from the inputs now applied.
  // A bit flips once s2 has disagreed with stable for more than m_lim edges.
  task automatic model_edge();
    logic [W-1:0] nst, rise, fall, clr;
    nst = m_stable;
    for (int i = 0; i < W; i++) begin
      if (m_s2[i] == m_stable[i]) begin
        m_div[i] = -1;
      end else begin
        if (m_div[i] < 0) m_div[i] = n_edge;
        if (n_edge - m_div[i] >= int'(m_lim)) begin
          nst[i]   = m_s2[i];
          m_div[i] = -1;
        end
      end
    end
    rise = nst & ~m_stable;
    fall = m_stable & ~nst;
    clr  = (cs && write && addr == 5'd3) ? wr_data[W-1:0] : '0;
    m_pend = ((rise & m_rise_en) | (fall & m_fall_en)) | (m_pend & ~clr);
    if (cs && write) begin
      case (addr)
        5'd1: m_rise_en = wr_data[W-1:0];
        5'd2: m_fall_en = wr_data[W-1:0];
        5'd4: m_lim     = wr_data[CW-1:0];
        5'd5: m_ctrl    = wr_data[0];
        default: ;
      endcase
    end
    m_s2 = m_s1;
    m_s1 = data_in;
    m_stable = nst;
    n_edge++;
  endtask

  // Sweep the register map (plus one unmapped address) and irq.
  task automatic check_regs(input string tag);
    int a;
    cs = 1'b0; write = 1'b0;
    check({tag, "_irq"}, 32'(irq), {31'd0, m_ctrl & (|m_pend)});
    for (int i = 0; i < 6; i++) begin
      addr = 5'(i); #1;
      check($sformatf("%s_reg%0d", tag, i), rd_data, exp_reg(i));
    end
    a = $urandom_range(6, 31);
    addr = 5'(a); #1;
    check($sformatf("%s_reg%0d", tag, a), rd_data, 32'd0);
  endtask

  task automatic tick_bus(input logic c, input logic w, input logic [4:0] a, input logic [31:0] d);
    cs = c; write = w; addr = a; wr_data = d;
    read = $urandom_range(0, 1);
    model_edge();
    @(posedge clk); #1;
    check_regs("tick");
  endtask

  task automatic tick();
    tick_bus(1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic tick_wr(input logic [4:0] a, input logic [31:0] d);
    tick_bus(1'b1, 1'b1, a, d);
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [31:0] v);
    cs = 1'b0; write = 1'b0; addr = a; #1;
    v = rd_data;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset held across one clock edge, released mid-cycle.
  task automatic do_reset();
    reset = 1'b1; #1;
    model_reset();
    check("rst_irq", 32'(irq), 32'd0);
    for (int i = 0; i < 6; i++) begin
      addr = 5'(i); #1;
      check($sformatf("rst_reg%0d", i), rd_data, 32'd0);
    end
    @(posedge clk); #5;
    reset = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    #2;
    do_reset();

    // Synchroniser latency with DB_LIMIT=0.
    data_in = 8'hA5;
    tick();                                  // edge k
    read_reg(5'd0, v); check("t1_data_k", v, 32'h0);
    tick();                                  // edge k+1
    read_reg(5'd0, v); check("t1_data_k1", v, 32'h0);
    tick();                                  // edge k+2
    read_reg(5'd0, v); check("t1_data_k2", v, 32'hA5);
    check("t1_irq", 32'(irq), 32'd0);

    // Glitch rejection and exact latency with DB_LIMIT=10.
    data_in = 8'h00; ticks(3);
    tick_wr(5'd4, 32'd10);
    data_in = 8'h01; ticks(5);
    data_in = 8'h00; ticks(20);
    read_reg(5'd0, v); check("t2_glitch_data", v, 32'h0);
    read_reg(5'd3, v); check("t2_glitch_pend", v, 32'h0);
    data_in = 8'h01;
    ticks(12);                               // edges k..k+11
    read_reg(5'd0, v); check("t2_data_k11", v, 32'h0);
    tick();                                  // edge k+12
    read_reg(5'd0, v); check("t2_data_k12", v, 32'h1);
    ticks(7);

    // Rising-edge interrupt and W1C.
    tick_wr(5'd4, 32'd0);
    tick_wr(5'd1, 32'h01);
    tick_wr(5'd5, 32'h1);
    data_in = 8'h00; ticks(3);
    data_in = 8'h01;
    ticks(2);
    read_reg(5'd3, v); check("t3_pend_k1", v, 32'h0);
    tick();
    read_reg(5'd3, v); check("t3_pend_k2", v, 32'h1);
    check("t3_irq_set", 32'(irq), 32'd1);
    tick_wr(5'd3, 32'h1);
    read_reg(5'd3, v); check("t3_pend_clr", v, 32'h0);
    check("t3_irq_clr", 32'(irq), 32'd0);

    // Set wins over a same-edge W1C on PENDING[7].
    tick_wr(5'd1, 32'h80);
    data_in = 8'h81; ticks(3);
    read_reg(5'd3, v); check("t4_pend7_set", v & 32'h80, 32'h80);
    tick_wr(5'd2, 32'h80);
    data_in = 8'h01;
    ticks(2);                                // edges k, k+1
    tick_wr(5'd3, 32'h80);                   // fall lands on edge k+2
    read_reg(5'd3, v); check("t4_set_wins", v & 32'h80, 32'h80);

    // Global enable gating and unmapped reads.
    tick_wr(5'd3, 32'hFF);
    tick_wr(5'd2, 32'h00);
    tick_wr(5'd5, 32'h0);
    tick_wr(5'd1, 32'h03);
    data_in = 8'h00; ticks(3);
    data_in = 8'h03; ticks(3);
    read_reg(5'd3, v); check("t5_pend", v, 32'h03);
    check("t5_irq_off", 32'(irq), 32'd0);
    tick_wr(5'd5, 32'h1);
    check("t5_irq_on", 32'(irq), 32'd1);
    read_reg(5'd6, v);  check("t5_addr6", v, 32'h0);
    read_reg(5'd31, v); check("t5_addr31", v, 32'h0);

    // Reset in the middle of a long debounce.
    data_in = 8'h00; ticks(3);
    tick_wr(5'd4, 32'd100);
    data_in = 8'h01; ticks(52);
    read_reg(5'd0, v); check("t6_mid_data", v, 32'h0);
    do_reset();
    ticks(2);
    read_reg(5'd0, v); check("t6_post_k1", v, 32'h0);
    tick();
    read_reg(5'd0, v); check("t6_post_k2", v, 32'h1);
    read_reg(5'd3, v); check("t6_no_pend", v, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [4:0]  a;
      logic [31:0] d;
      if ($urandom_range(0, 3) == 0) data_in = W'($urandom);
      r = $urandom_range(0, 99);
      if (r == 0) begin
        do_reset();
      end else if (r < 35) begin
        a = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(6, 31)) : 5'($urandom_range(0, 5));
        d = (a == 5'd4) ? 32'($urandom_range(0, 4)) | ($urandom & 32'hFFFF_0000) : $urandom;
        tick_bus($urandom_range(0, 7) != 0, 1'b1, a, d);
      end else if (r < 40) begin
        tick_bus(1'b0, 1'b1, 5'($urandom_range(1, 5)), $urandom);
      end else begin
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
